// File: rtl/norm_scan_unit_if.sv
// Request/response bundle for the normalizer / zero-count unit.
// The master side is the pipeline that issues the scan; the slave side is the unit.
interface norm_scan_unit_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
);
  logic             i_start;
  logic             i_mode;
  logic [WIDTH-1:0] i_data;
  logic             o_busy;
  logic             o_done;
  logic [CNT_W-1:0] o_count;
  logic [WIDTH-1:0] o_norm;
  logic             o_zero;

  modport master (
    output i_start, i_mode, i_data,
    input  o_busy, o_done, o_count, o_norm, o_zero
  );

  modport slave (
    input  i_start, i_mode, i_data,
    output o_busy, o_done, o_count, o_norm, o_zero
  );
endinterface

// File: rtl/norm_scan_unit.sv
// Multi-cycle CLZ/CTZ normalizer: a binary search of shifts by 16,8,4,2,1,
// one step per clock, followed by a single-cycle done pulse.
module norm_scan_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          i_clk,
  input  logic          i_reset,
  norm_scan_unit_if.slave bus
);

  localparam logic [2:0] LAST_STEP = 3'd4;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       step;
  logic             mode;

  logic [4:0]       k;
  logic [WIDTH-1:0] hi_mask, lo_mask, work_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             hit;

  // Step size halves each cycle; masks select the k bits at the scanned end.
  always_comb begin
    k        = 5'd16 >> step;
    hi_mask  = ~({WIDTH{1'b1}} >> k);
    lo_mask  = ~({WIDTH{1'b1}} << k);
    hit      = mode ? ((work & lo_mask) == '0) : ((work & hi_mask) == '0);
    work_nxt = work;
    cnt_nxt  = cnt;
    if (hit) begin
      work_nxt = mode ? (work >> k) : (work << k);
      cnt_nxt  = cnt + CNT_W'(k);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_start) state_d = SCAN;
      SCAN:    if (step == LAST_STEP) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      work        <= '0;
      cnt         <= '0;
      step        <= '0;
      mode        <= 1'b0;
      bus.o_busy  <= 1'b0;
      bus.o_done  <= 1'b0;
      bus.o_count <= '0;
      bus.o_norm  <= '0;
      bus.o_zero  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.i_start) begin
          work       <= bus.i_data;
          cnt        <= '0;
          step       <= '0;
          mode       <= bus.i_mode;
          bus.o_busy <= 1'b1;
        end
        SCAN: begin
          work <= work_nxt;
          cnt  <= cnt_nxt;
          step <= step + 3'd1;
          if (step == LAST_STEP) begin
            bus.o_busy <= 1'b0;
            bus.o_done <= 1'b1;
            // All-zero operand is the only way to reach 32; the search tops out at 31.
            if (work_nxt == '0) begin
              bus.o_count <= CNT_W'(WIDTH);
              bus.o_norm  <= '0;
              bus.o_zero  <= 1'b1;
            end else begin
              bus.o_count <= cnt_nxt;
              bus.o_norm  <= work_nxt;
              bus.o_zero  <= 1'b0;
            end
          end
        end
        DONE:    bus.o_done <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_norm_scan_unit.sv
// Directed and random checks of norm_scan_unit against a bit-search reference model.
module tb_norm_scan_unit;

  logic i_clk = 1'b0;
  logic i_reset;
  int   checks = 0;
  int   errors = 0;

  logic [5:0]  prev_cnt;
  logic [31:0] prev_norm;
  logic        prev_zero;

  norm_scan_unit_if bus ();

  norm_scan_unit dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: locate the first set bit from the scanned end.
  task automatic ref_model(input logic m, input logic [31:0] d,
                           output logic [5:0] c, output logic [31:0] n, output logic z);
    int i;
    if (d == 32'd0) begin
      c = 6'd32; n = 32'd0; z = 1'b1;
    end else begin
      i = 0;
      if (m == 1'b0) while (d[31 - i] == 1'b0) i++;
      else           while (d[i] == 1'b0) i++;
      c = 6'(i);
      n = m ? (d >> i) : (d << i);
      z = 1'b0;
    end
  endtask

  // Issue one operation from an idle state and follow it cycle by cycle through DONE.
  task automatic do_op(input logic m, input logic [31:0] d, input bit hold_start);
    logic [5:0]  ec;
    logic [31:0] en;
    logic        ez;
    ref_model(m, d, ec, en, ez);
    bus.i_start = 1'b1;
    bus.i_mode  = m;
    bus.i_data  = d;
    @(posedge i_clk); #1;
    if (!hold_start) begin
      bus.i_start = 1'b0;
      bus.i_mode  = ~m;
      bus.i_data  = $urandom;
    end
    chk("busy_after_accept", 32'(bus.o_busy), 32'd1);
    chk("done_after_accept", 32'(bus.o_done), 32'd0);
    chk("count_held_on_start", 32'(bus.o_count), 32'(prev_cnt));
    for (int c = 1; c <= 5; c++) begin
      @(posedge i_clk); #1;
      if (hold_start) begin
        bus.i_data = $urandom;
        bus.i_mode = 1'($urandom);
      end
      if (c < 5) begin
        chk("busy_in_scan", 32'(bus.o_busy), 32'd1);
        chk("done_in_scan", 32'(bus.o_done), 32'd0);
        chk("norm_held_in_scan", bus.o_norm, prev_norm);
      end else begin
        chk("busy_at_done", 32'(bus.o_busy), 32'd0);
        chk("done_pulse", 32'(bus.o_done), 32'd1);
        chk("count", 32'(bus.o_count), 32'(ec));
        chk("norm", bus.o_norm, en);
        chk("zero", 32'(bus.o_zero), 32'(ez));
      end
    end
    bus.i_start = 1'b0;
    @(posedge i_clk); #1;
    chk("done_cleared", 32'(bus.o_done), 32'd0);
    chk("busy_idle", 32'(bus.o_busy), 32'd0);
    chk("count_persist", 32'(bus.o_count), 32'(ec));
    prev_cnt = ec; prev_norm = en; prev_zero = ez;
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_mode  = 1'b0;
    bus.i_data  = '0;
    i_reset     = 1'b0;
    prev_cnt = '0; prev_norm = '0; prev_zero = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_done", 32'(bus.o_done), 32'd0);
    chk("rst_zero", 32'(bus.o_zero), 32'd0);
    chk("rst_count", 32'(bus.o_count), 32'd0);
    chk("rst_norm", bus.o_norm, 32'd0);
    i_reset = 1'b1;
    @(posedge i_clk); #1;

    // Reset in the middle of a scan aborts with no done pulse.
    bus.i_start = 1'b1; bus.i_mode = 1'b0; bus.i_data = 32'h0000_0001;
    @(posedge i_clk); #1;
    bus.i_start = 1'b0;
    repeat (2) @(posedge i_clk);
    #2;
    i_reset = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.o_busy), 32'd0);
    chk("abort_count", 32'(bus.o_count), 32'd0);
    chk("abort_norm", bus.o_norm, 32'd0);
    for (int c = 0; c < 6; c++) begin
      @(posedge i_clk); #1;
      chk("abort_no_done", 32'(bus.o_done), 32'd0);
    end
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    do_op(1'b0, 32'h0000_0001, 1'b0);

    // Directed patterns and boundaries.
    do_op(1'b0, 32'h0000_1000, 1'b0);
    do_op(1'b1, 32'h00F0_0000, 1'b0);
    do_op(1'b0, 32'h8000_0000, 1'b0);
    do_op(1'b1, 32'h8000_0000, 1'b0);
    do_op(1'b0, 32'h0000_0000, 1'b0);
    do_op(1'b1, 32'h0000_0000, 1'b0);
    do_op(1'b1, 32'h0000_0001, 1'b0);
    do_op(1'b0, 32'hFFFF_FFFF, 1'b0);
    do_op(1'b1, 32'hFFFF_FFFF, 1'b0);

    // Start held high with a changing operand during the scan.
    do_op(1'b0, 32'h0003_0000, 1'b1);
    do_op(1'b1, 32'h0000_0400, 1'b1);

    // Random sweep, biased toward many leading/trailing zeros.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] d;
      d = $urandom;
      d = d >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) d = d << $urandom_range(0, 31);
      do_op(1'($urandom), d, 1'($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
